// File: rtl/uart_cfg_sequencer_if.sv
// Configuration-sequencer bus bundle: sequence request, payload stream and config-bus writes.
// The master drives requests and payload; the slave drives the config bus and status.
interface uart_cfg_sequencer_if #(
  parameter int LEN_W = 4
);
  logic             seq_start;
  logic             seq_abort;
  logic [7:0]       seq_slave_addr;
  logic [7:0]       seq_self_addr;
  logic [7:0]       seq_stop_frame;
  logic [7:0]       seq_baud_cmp;
  logic [LEN_W-1:0] seq_len;
  logic             pl_valid;
  logic [7:0]       pl_data;
  logic             pl_ready;
  logic             tx_fifo_full;
  logic [4:0]       usr_data_addr;
  logic [7:0]       usr_data_cfgdata;
  logic             usr_ctrl_wnr;
  logic             seq_busy;
  logic             seq_done;

  modport master (
    output seq_start, seq_abort, seq_slave_addr, seq_self_addr, seq_stop_frame,
           seq_baud_cmp, seq_len, pl_valid, pl_data, tx_fifo_full,
    input  pl_ready, usr_data_addr, usr_data_cfgdata, usr_ctrl_wnr, seq_busy, seq_done
  );

  modport slave (
    input  seq_start, seq_abort, seq_slave_addr, seq_self_addr, seq_stop_frame,
           seq_baud_cmp, seq_len, pl_valid, pl_data, tx_fifo_full,
    output pl_ready, usr_data_addr, usr_data_cfgdata, usr_ctrl_wnr, seq_busy, seq_done
  );
endinterface

// File: rtl/uart_cfg_sequencer.sv
// Writes a fixed UART configuration sequence onto the config bus, streams the payload
// bytes into the TX FIFO register, then enables RX and TX.
module uart_cfg_sequencer #(
  parameter int LEN_W = 4
) (
  input logic                  glb_clk,
  input logic                  glb_rstn,
  uart_cfg_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_SLV  = 4'd1,
    S_W_SELF = 4'd2,
    S_W_STOP = 4'd3,
    S_W_BAUD = 4'd4,
    S_LOAD   = 4'd5,
    S_EN_RX  = 4'd6,
    S_EN_TX  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       slv_q, slv_d;
  logic [7:0]       self_q, self_d;
  logic [7:0]       stop_q, stop_d;
  logic [7:0]       baud_q, baud_d;
  logic [4:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wnr_q, wnr_d;
  logic             pl_ready_s;

  // An abort on the same edge suppresses acceptance so the producer keeps its byte.
  assign pl_ready_s = (state_q == S_LOAD) && !bus.tx_fifo_full && (cnt_q != len_q) &&
                      !bus.seq_abort;

  assign bus.pl_ready         = pl_ready_s;
  assign bus.usr_data_addr    = addr_q;
  assign bus.usr_data_cfgdata = data_q;
  assign bus.usr_ctrl_wnr     = wnr_q;
  assign bus.seq_busy         = (state_q != S_IDLE);
  assign bus.seq_done         = (state_q == S_DONE);

  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      slv_q   <= 8'd0;
      self_q  <= 8'd0;
      stop_q  <= 8'd0;
      baud_q  <= 8'd0;
      addr_q  <= 5'd0;
      data_q  <= 8'd0;
      wnr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      slv_q   <= slv_d;
      self_q  <= self_d;
      stop_q  <= stop_d;
      baud_q  <= baud_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wnr_q   <= wnr_d;
    end
  end

  // Bus value computed here is the one for the state being entered on the coming edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    slv_d   = slv_q;
    self_d  = self_q;
    stop_d  = stop_q;
    baud_d  = baud_q;
    addr_d  = 5'd0;
    data_d  = 8'd0;
    wnr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.seq_start && !bus.seq_abort) begin
          slv_d   = bus.seq_slave_addr;
          self_d  = bus.seq_self_addr;
          stop_d  = bus.seq_stop_frame;
          baud_d  = bus.seq_baud_cmp;
          len_d   = bus.seq_len;
          state_d = S_W_SLV;
          addr_d  = 5'd2;
          data_d  = bus.seq_slave_addr;
          wnr_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_SLV: begin
        state_d = S_W_SELF;
        addr_d  = 5'd3;
        data_d  = self_q;
        wnr_d   = 1'b1;
      end
      S_W_SELF: begin
        state_d = S_W_STOP;
        addr_d  = 5'd4;
        data_d  = stop_q;
        wnr_d   = 1'b1;
      end
      S_W_STOP: begin
        state_d = S_W_BAUD;
        addr_d  = 5'd5;
        data_d  = baud_q;
        wnr_d   = 1'b1;
      end
      S_W_BAUD: begin
        cnt_d = '0;
        if (len_q != '0) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_EN_RX;
          addr_d  = 5'd1;
          data_d  = 8'd1;
          wnr_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (cnt_q == len_q) begin
          state_d = S_EN_RX;
          addr_d  = 5'd1;
          data_d  = 8'd1;
          wnr_d   = 1'b1;
        end else if (bus.pl_valid && pl_ready_s) begin
          cnt_d  = cnt_q + LEN_W'(1);
          addr_d = 5'd6;
          data_d = bus.pl_data;
          wnr_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_EN_RX: begin
        state_d = S_EN_TX;
        addr_d  = 5'd0;
        data_d  = 8'd1;
        wnr_d   = 1'b1;
      end
      S_EN_TX: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && bus.seq_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      addr_d  = 5'd0;
      data_d  = 8'd0;
      wnr_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Bench for uart_cfg_sequencer: table of sequences checked against a write scoreboard,
// plus hand-written abort, start+abort and mid-sequence reset scenarios.
module tb_uart_cfg_sequencer;

  localparam int LEN_W = 4;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [7:0]       slv;
    logic [7:0]       slf;
    logic [7:0]       stp;
    logic [7:0]       bd;
    logic [7:0]       dbase;
    int               full_cyc;
    int               exp_lat;
  } vec_t;

  logic glb_clk;
  logic glb_rstn;
  int   total;
  int   bad;
  int   done_seen;
  int   done_exp;
  wr_t  exp_q[$];
  vec_t tbl[5];

  uart_cfg_sequencer_if #(.LEN_W(LEN_W)) bus ();

  uart_cfg_sequencer #(.LEN_W(LEN_W)) dut (
    .glb_clk  (glb_clk),
    .glb_rstn (glb_rstn),
    .bus      (bus.slave)
  );

  initial glb_clk = 1'b0;
  always #5 glb_clk = ~glb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Scoreboard consumer: every write must match the next expected one; otherwise the bus is idle.
  always @(negedge glb_clk) begin
    if (glb_rstn) begin
      if (bus.seq_done) done_seen++;
      if (bus.usr_ctrl_wnr) begin
        if (exp_q.size() == 0) begin
          chk("stray_write_wnr", 32'(bus.usr_ctrl_wnr), 32'd0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 32'(bus.usr_data_addr), 32'(w.addr));
          chk("wr_data", 32'(bus.usr_data_cfgdata), 32'(w.data));
        end
      end else begin
        chk("idle_bus", {19'd0, bus.usr_data_addr, bus.usr_data_cfgdata}, 32'd0);
      end
    end
  end

  task automatic run_seq(input vec_t r);
    int idx;
    int k;
    int got;
    logic hs;
    idx = 0;
    got = -1;
    @(negedge glb_clk);
    bus.seq_slave_addr = r.slv;
    bus.seq_self_addr  = r.slf;
    bus.seq_stop_frame = r.stp;
    bus.seq_baud_cmp   = r.bd;
    bus.seq_len        = r.len;
    bus.seq_start      = 1'b1;
    push_wr(5'd2, r.slv);
    push_wr(5'd3, r.slf);
    push_wr(5'd4, r.stp);
    push_wr(5'd5, r.bd);
    for (int i = 0; i < int'(r.len); i++) push_wr(5'd6, r.dbase + 8'(i));
    push_wr(5'd1, 8'd1);
    push_wr(5'd0, 8'd1);
    done_exp++;
    @(posedge glb_clk);
    k = 0;
    while (k < 60) begin
      @(negedge glb_clk);
      if (bus.seq_done) begin
        got = k;
        break;
      end
      // Values changed and start repeated mid-sequence must have no effect.
      bus.seq_start      = (k == 2);
      bus.seq_slave_addr = ~r.slv;
      bus.seq_self_addr  = ~r.slf;
      bus.seq_stop_frame = ~r.stp;
      bus.seq_baud_cmp   = ~r.bd;
      bus.seq_len        = ~r.len;
      bus.pl_valid       = (idx < int'(r.len));
      bus.pl_data        = r.dbase + 8'(idx);
      bus.tx_fifo_full   = (k + 1 >= 5) && (k + 1 < 5 + r.full_cyc);
      #1;
      if (bus.tx_fifo_full) chk("ready_while_full", 32'(bus.pl_ready), 32'd0);
      hs = bus.pl_valid & bus.pl_ready;
      @(posedge glb_clk);
      if (hs) idx++;
      k++;
    end
    chk("done_lat", 32'(got), 32'(r.exp_lat));
    bus.seq_start    = 1'b0;
    bus.pl_valid     = 1'b0;
    bus.tx_fifo_full = 1'b0;
    @(posedge glb_clk);
    @(negedge glb_clk);
    chk("idle_after_done", {30'd0, bus.seq_busy, bus.seq_done}, 32'd0);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_seen = 0;
    done_exp = 0;
    tbl[0] = '{len: 4'd0,  slv: 8'h11, slf: 8'h22, stp: 8'h33, bd: 8'h44, dbase: 8'h00, full_cyc: 0, exp_lat: 6};
    tbl[1] = '{len: 4'd3,  slv: 8'h5A, slf: 8'hC3, stp: 8'h01, bd: 8'h7F, dbase: 8'hA1, full_cyc: 0, exp_lat: 10};
    tbl[2] = '{len: 4'd2,  slv: 8'hFE, slf: 8'h10, stp: 8'h80, bd: 8'h0D, dbase: 8'h60, full_cyc: 5, exp_lat: 14};
    tbl[3] = '{len: 4'd15, slv: 8'h01, slf: 8'h02, stp: 8'h03, bd: 8'h04, dbase: 8'hE0, full_cyc: 0, exp_lat: 22};
    tbl[4] = '{len: 4'd1,  slv: 8'h99, slf: 8'h88, stp: 8'h77, bd: 8'h66, dbase: 8'h42, full_cyc: 2, exp_lat: 10};

    glb_rstn           = 1'b0;
    bus.seq_start      = 1'b0;
    bus.seq_abort      = 1'b0;
    bus.seq_slave_addr = 8'd0;
    bus.seq_self_addr  = 8'd0;
    bus.seq_stop_frame = 8'd0;
    bus.seq_baud_cmp   = 8'd0;
    bus.seq_len        = '0;
    bus.pl_valid       = 1'b0;
    bus.pl_data        = 8'd0;
    bus.tx_fifo_full   = 1'b0;
    #12;
    chk("reset_outputs", {16'd0, bus.usr_data_addr, bus.usr_data_cfgdata, bus.usr_ctrl_wnr,
                          bus.seq_busy, bus.seq_done}, 32'd0);
    chk("reset_ready", 32'(bus.pl_ready), 32'd0);
    @(negedge glb_clk);
    glb_rstn = 1'b1;

    for (int t = 0; t < 5; t++) run_seq(tbl[t]);

    // Start together with abort in IDLE stays idle.
    @(negedge glb_clk);
    bus.seq_start = 1'b1;
    bus.seq_abort = 1'b1;
    @(posedge glb_clk);
    @(negedge glb_clk);
    bus.seq_start = 1'b0;
    bus.seq_abort = 1'b0;
    chk("start_abort_idle", 32'(bus.seq_busy), 32'd0);

    // Abort in LOAD after one byte; the pending second byte must not be written.
    bus.seq_slave_addr = 8'hB1;
    bus.seq_self_addr  = 8'hB2;
    bus.seq_stop_frame = 8'hB3;
    bus.seq_baud_cmp   = 8'hB4;
    bus.seq_len        = 4'd3;
    bus.seq_start      = 1'b1;
    bus.pl_valid       = 1'b1;
    bus.pl_data        = 8'h30;
    push_wr(5'd2, 8'hB1);
    push_wr(5'd3, 8'hB2);
    push_wr(5'd4, 8'hB3);
    push_wr(5'd5, 8'hB4);
    push_wr(5'd6, 8'h30);
    @(posedge glb_clk);
    #1 bus.seq_start = 1'b0;
    repeat (5) @(posedge glb_clk);
    @(negedge glb_clk);
    bus.pl_data   = 8'h31;
    bus.seq_abort = 1'b1;
    chk("busy_before_abort", 32'(bus.seq_busy), 32'd1);
    @(posedge glb_clk);
    @(negedge glb_clk);
    bus.seq_abort = 1'b0;
    bus.pl_valid  = 1'b0;
    chk("abort_idle", {30'd0, bus.seq_busy, bus.usr_ctrl_wnr}, 32'd0);
    repeat (3) @(posedge glb_clk);
    chk("abort_sb_drain", 32'(exp_q.size()), 32'd0);
    run_seq(tbl[1]);

    // Reset while in W_STOP: outputs clear at once, nothing written after release.
    @(negedge glb_clk);
    bus.seq_slave_addr = 8'hC1;
    bus.seq_self_addr  = 8'hC2;
    bus.seq_stop_frame = 8'hC3;
    bus.seq_baud_cmp   = 8'hC4;
    bus.seq_len        = 4'd0;
    bus.seq_start      = 1'b1;
    push_wr(5'd2, 8'hC1);
    push_wr(5'd3, 8'hC2);
    push_wr(5'd4, 8'hC3);
    @(posedge glb_clk);
    #1 bus.seq_start = 1'b0;
    repeat (2) @(posedge glb_clk);
    @(negedge glb_clk);
    #2 glb_rstn = 1'b0;
    #1;
    chk("async_reset_outputs", {16'd0, bus.usr_data_addr, bus.usr_data_cfgdata, bus.usr_ctrl_wnr,
                                bus.seq_busy, bus.seq_done}, 32'd0);
    repeat (2) @(posedge glb_clk);
    @(negedge glb_clk);
    glb_rstn = 1'b1;
    repeat (6) @(posedge glb_clk);
    @(negedge glb_clk);
    chk("post_reset_idle", 32'(bus.seq_busy), 32'd0);
    chk("reset_sb_drain", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_seen), 32'(done_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
